// File: rtl/decode_stage_param.sv
// Decode stage: register file with write-through bypass, bounded return-address
// stack with sticky error flags, and a programmable-length NOP bubble generator.
module decode_stage_param #(
   parameter int          DATA_W        = 8,
   parameter int          PC_W          = 12,
   parameter int          STACK_DEPTH   = 8,
   parameter int          BUBBLE_CYCLES = 1,
   parameter logic [18:0] NOP_INSTR     = {6'b111101, 13'd0}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [18:0]       instruction,
   input  logic              sstall,
   input  logic              ctrl_stall,
   output logic [18:0]       ctrl_instr,
   output logic              bubble_active,
   input  logic              push,
   input  logic              pop,
   input  logic              r2_sel,
   input  logic              reg_write,
   input  logic [2:0]        write_address,
   input  logic [DATA_W-1:0] write_data,
   output logic [2:0]        r1_address,
   output logic [2:0]        r2_address,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic [2:0]        dest,
   output logic [2:0]        shift_count,
   output logic [7:0]        const_disp,
   input  logic [PC_W-1:0]   stack_in,
   output logic [PC_W-1:0]   stack_out,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_overflow,
   output logic              stack_underflow
);

   localparam int BC_W = $clog2(BUBBLE_CYCLES + 1);
   localparam int SP_W = $clog2(STACK_DEPTH + 1);
   localparam int AW   = $clog2(STACK_DEPTH);

   logic [BC_W-1:0]   r_bcnt_p1;
   logic [DATA_W-1:0] r_regs [8];
   logic [PC_W-1:0]   r_mem [STACK_DEPTH];
   logic [SP_W-1:0]   r_sp;
   logic              r_ovf;
   logic              r_unf;

   logic [AW-1:0]     w_top_idx;
   logic [AW-1:0]     w_mem_idx;
   logic              w_mem_we;
   logic              w_full;
   logic              w_empty;

   // Stage boundary: stall request registered into the bubble counter (reload, not add)
   always_ff @(posedge clk) begin
      if (rst)
         r_bcnt_p1 <= '0;
      else if (ctrl_stall)
         r_bcnt_p1 <= BC_W'(BUBBLE_CYCLES);
      else if (r_bcnt_p1 != '0)
         r_bcnt_p1 <= r_bcnt_p1 - 1'b1;
   end

   assign bubble_active = (r_bcnt_p1 != '0);
   assign ctrl_instr    = (sstall || bubble_active) ? NOP_INSTR : instruction;

   assign dest        = instruction[13:11];
   assign shift_count = instruction[7:5];
   assign const_disp  = instruction[7:0];
   assign r1_address  = instruction[10:8];
   assign r2_address  = r2_sel ? instruction[13:11] : instruction[7:5];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++)
            r_regs[i] <= '0;
      end else if (reg_write) begin
         r_regs[write_address] <= write_data;
      end
   end

   assign read_data1 = (reg_write && write_address == r1_address) ? write_data : r_regs[r1_address];
   assign read_data2 = (reg_write && write_address == r2_address) ? write_data : r_regs[r2_address];

   assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
   assign w_empty   = (r_sp == '0);
   assign w_top_idx = AW'(r_sp - 1'b1);

   // Push+pop on a non-empty stack rewrites the top; on an empty stack it is a plain push.
   always_comb begin
      w_mem_we  = 1'b0;
      w_mem_idx = '0;
      if (!rst && push) begin
         if (pop && !w_empty) begin
            w_mem_we  = 1'b1;
            w_mem_idx = w_top_idx;
         end else if (!w_full) begin
            w_mem_we  = 1'b1;
            w_mem_idx = AW'(r_sp);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[w_mem_idx] <= stack_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (push && pop) begin
         if (w_empty)
            r_sp <= SP_W'(1);
      end else if (push) begin
         if (w_full)
            r_ovf <= 1'b1;
         else
            r_sp <= r_sp + 1'b1;
      end else if (pop) begin
         if (w_empty)
            r_unf <= 1'b1;
         else
            r_sp <= r_sp - 1'b1;
      end
   end

   assign stack_out       = w_empty ? '0 : r_mem[w_top_idx];
   assign stack_full      = w_full;
   assign stack_empty     = w_empty;
   assign stack_overflow  = r_ovf;
   assign stack_underflow = r_unf;

endmodule

// File: tb/tb_decode_stage_param.sv
// Directed-vector bench for decode_stage_param with BUBBLE_CYCLES=3, STACK_DEPTH=8.
module tb_decode_stage_param;

   localparam int          DATA_W = 8;
   localparam int          PC_W   = 12;
   localparam logic [18:0] NOP    = {6'b111101, 13'd0};

   logic              clk = 1'b0;
   logic              rst;
   logic [18:0]       instr;
   logic              sstall, ctrl_stall, push, pop, r2_sel, reg_write;
   logic [2:0]        write_address;
   logic [DATA_W-1:0] write_data;
   logic [PC_W-1:0]   stack_in;
   logic [18:0]       ctrl_instr;
   logic              bubble_active;
   logic [2:0]        r1_address, r2_address, dest, shift_count;
   logic [DATA_W-1:0] read_data1, read_data2;
   logic [7:0]        const_disp;
   logic [PC_W-1:0]   stack_out;
   logic              stack_full, stack_empty, stack_overflow, stack_underflow;

   int n_vec = 0;
   int n_err = 0;

   decode_stage_param #(
      .DATA_W(DATA_W), .PC_W(PC_W), .STACK_DEPTH(8), .BUBBLE_CYCLES(3), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .rst(rst), .instruction(instr), .sstall(sstall), .ctrl_stall(ctrl_stall),
      .ctrl_instr(ctrl_instr), .bubble_active(bubble_active), .push(push), .pop(pop),
      .r2_sel(r2_sel), .reg_write(reg_write), .write_address(write_address),
      .write_data(write_data), .r1_address(r1_address), .r2_address(r2_address),
      .read_data1(read_data1), .read_data2(read_data2), .dest(dest),
      .shift_count(shift_count), .const_disp(const_disp), .stack_in(stack_in),
      .stack_out(stack_out), .stack_full(stack_full), .stack_empty(stack_empty),
      .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic run_bubble(input string tag, input logic [7:0] stalls, input logic [7:0] nops);
      for (int i = 0; i < 8; i++) begin
         ctrl_stall = stalls[i];
         @(negedge clk);
         chk({tag, "_instr"}, 32'(ctrl_instr), nops[i] ? 32'(NOP) : 32'(instr));
         chk({tag, "_active"}, 32'(bubble_active), 32'(nops[i]));
         nxt();
      end
      ctrl_stall = 1'b0;
   endtask

   initial begin
      rst = 1'b1; instr = 19'h4D9E6; sstall = 0; ctrl_stall = 0; push = 0; pop = 0;
      r2_sel = 0; reg_write = 0; write_address = 0; write_data = 0; stack_in = 0;
      nxt(); nxt();
      rst = 1'b0;

      // build stale state: underflow, a pushed entry, a written register, a pending bubble
      pop = 1; nxt(); pop = 0;
      @(negedge clk);
      chk("unf_set", 32'(stack_underflow), 1);
      push = 1; stack_in = 12'h555; nxt(); push = 0;
      reg_write = 1; write_address = 3'd1; write_data = 8'h3C; nxt(); reg_write = 0;
      @(negedge clk);
      chk("stale_r1", 32'(read_data1), 'h3C);
      chk("stale_top", 32'(stack_out), 'h555);
      ctrl_stall = 1; nxt(); ctrl_stall = 0;
      rst = 1; nxt(); rst = 0;
      @(negedge clk);
      chk("rst_r1", 32'(read_data1), 0);
      chk("rst_r2", 32'(read_data2), 0);
      chk("rst_top", 32'(stack_out), 0);
      chk("rst_empty", 32'(stack_empty), 1);
      chk("rst_full", 32'(stack_full), 0);
      chk("rst_unf", 32'(stack_underflow), 0);
      chk("rst_ovf", 32'(stack_overflow), 0);
      chk("rst_bub", 32'(bubble_active), 0);
      chk("rst_instr", 32'(ctrl_instr), 32'(instr));

      // field slices: 4D9E6 -> dest 3, shift 7, const E6, r1 1, r2 7 / 3
      chk("f_dest", 32'(dest), 3);
      chk("f_shift", 32'(shift_count), 7);
      chk("f_const", 32'(const_disp), 'hE6);
      chk("f_r1a", 32'(r1_address), 1);
      chk("f_r2a0", 32'(r2_address), 7);
      r2_sel = 1; #1;
      chk("f_r2a1", 32'(r2_address), 3);
      r2_sel = 0;
      nxt();

      // push+pop on empty stack behaves as push, no underflow
      push = 1; pop = 1; stack_in = 12'h123; nxt(); push = 0; pop = 0;
      @(negedge clk);
      chk("pp0_top", 32'(stack_out), 'h123);
      chk("pp0_empty", 32'(stack_empty), 0);
      chk("pp0_unf", 32'(stack_underflow), 0);
      pop = 1; nxt(); pop = 0;
      @(negedge clk);
      chk("pp0_sp1", 32'(stack_empty), 1);
      chk("pp0_unf2", 32'(stack_underflow), 0);
      nxt();

      // bubbles: single pulse, then re-pulse two cycles later, then sstall
      run_bubble("bubA", 8'b0000_0001, 8'b0000_1110);
      run_bubble("bubB", 8'b0000_0101, 8'b0011_1110);
      sstall = 1;
      @(negedge clk);
      chk("sst_instr", 32'(ctrl_instr), 32'(NOP));
      chk("sst_active", 32'(bubble_active), 0);
      nxt(); sstall = 0;
      @(negedge clk);
      chk("sst_after", 32'(ctrl_instr), 32'(instr));
      nxt();

      // register file bypass on R3 via both ports
      instr = 19'h01B00; r2_sel = 1;
      reg_write = 1; write_address = 3'd3; write_data = 8'hA5;
      @(negedge clk);
      chk("byp_rd1", 32'(read_data1), 'hA5);
      chk("byp_rd2", 32'(read_data2), 'hA5);
      nxt(); reg_write = 0;
      @(negedge clk);
      chk("st_rd1", 32'(read_data1), 'hA5);
      chk("st_rd2", 32'(read_data2), 'hA5);
      nxt();
      instr = 19'h01B60; r2_sel = 0;
      reg_write = 1; write_address = 3'd4; write_data = 8'h11;
      @(negedge clk);
      chk("nobyp_rd1", 32'(read_data1), 'hA5);
      chk("nobyp_rd2", 32'(read_data2), 'hA5);
      nxt(); reg_write = 0;
      instr = 19'h01460;
      @(negedge clk);
      chk("r4_rd1", 32'(read_data1), 'h11);
      nxt();

      // fill, overflow, drain, underflow
      for (int i = 1; i <= 8; i++) begin
         push = 1; stack_in = PC_W'(i); nxt();
      end
      push = 0;
      @(negedge clk);
      chk("fill_full", 32'(stack_full), 1);
      chk("fill_top", 32'(stack_out), 8);
      chk("fill_ovf0", 32'(stack_overflow), 0);
      push = 1; stack_in = 12'h0FF; nxt(); push = 0;
      @(negedge clk);
      chk("ovf_flag", 32'(stack_overflow), 1);
      chk("ovf_top", 32'(stack_out), 8);
      for (int i = 1; i <= 8; i++) begin
         pop = 1; nxt(); pop = 0;
         @(negedge clk);
         chk($sformatf("pop%0d_top", i), 32'(stack_out), 32'(8 - i));
      end
      chk("drain_empty", 32'(stack_empty), 1);
      chk("drain_unf0", 32'(stack_underflow), 0);
      pop = 1; nxt(); pop = 0;
      @(negedge clk);
      chk("unf_flag", 32'(stack_underflow), 1);
      chk("ovf_sticky", 32'(stack_overflow), 1);

      // replace top with sp=2
      push = 1; stack_in = 12'h111; nxt();
      stack_in = 12'h222; nxt();
      pop = 1; stack_in = 12'h123; nxt(); push = 0; pop = 0;
      @(negedge clk);
      chk("rep_top", 32'(stack_out), 'h123);
      pop = 1; nxt(); pop = 0;
      @(negedge clk);
      chk("rep_below", 32'(stack_out), 'h111);
      push = 1; stack_in = 12'h333; nxt();
      stack_in = 12'h444; nxt();
      stack_in = 12'h555; nxt(); push = 0;

      // reset during bubble cycle 2 with sp=4; rst overrides stall and push
      ctrl_stall = 1; nxt(); ctrl_stall = 0;
      @(negedge clk);
      chk("mid_b1", 32'(ctrl_instr), 32'(NOP));
      nxt();
      rst = 1; ctrl_stall = 1; push = 1; stack_in = 12'h777;
      @(negedge clk);
      chk("mid_b2", 32'(ctrl_instr), 32'(NOP));
      chk("mid_sp4", 32'(stack_out), 'h555);
      nxt();
      rst = 0; ctrl_stall = 0; push = 0;
      @(negedge clk);
      chk("mid_instr", 32'(ctrl_instr), 32'(instr));
      chk("mid_empty", 32'(stack_empty), 1);
      chk("mid_top", 32'(stack_out), 0);
      chk("mid_unf", 32'(stack_underflow), 0);
      chk("mid_ovf", 32'(stack_overflow), 0);
      instr = 19'h01B00;
      #1;
      chk("mid_r3", 32'(read_data1), 0);
      nxt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_stage_param.md
# decode_stage_param

Parametrised instruction-decode stage (pipeline stage 2). Sits between the fetch stage and the execute stage and contains the register file with write-through bypass, a bounded return-address stack with full/empty and sticky error flags, and a bubble generator that substitutes a NOP for the instruction sent to the controller. The stall bubble length is programmable, where the previous stage was fixed at one cycle. The controller is outside this block: the block feeds it the bubble-muxed instruction and receives its stall, push, pop and r2-select outputs.

## Interface
- DATA_W, 8: register-file word width
- PC_W, 12: return-address (stack entry) width
- STACK_DEPTH, 8: number of stack entries, ≥2
- BUBBLE_CYCLES, 1: NOP cycles inserted per controller stall request, ≥1
- NOP_INSTR, {6'b111101,13'd0}: 19-bit instruction substituted during bubbles
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  19  instruction from fetch/decode pipeline register
- sstall  in  1  external stall; forces NOP to controller this cycle
- ctrl_stall  in  1  controller stall request (registered internally)
- ctrl_instr  out  19  instruction presented to controller
- bubble_active  out  1  bubble counter nonzero
- push, pop  in  1  stack controls from controller
- r2_sel  in  1  0: r2 address = instruction[7:5]; 1: instruction[13:11]
- reg_write  in  1  register-file write enable (from write-back)
- write_address  in  3  write-back register index
- write_data  in  DATA_W  write-back data
- r1_address, r2_address  out  3  read indices (instruction[10:8], muxed r2)
- read_data1, read_data2  out  DATA_W  read data
- dest  out  3  instruction[13:11]
- shift_count  out  3  instruction[7:5]
- const_disp  out  8  instruction[7:0]
- stack_in  in  PC_W  value to push
- stack_out  out  PC_W  top of stack
- stack_full, stack_empty  out  1  occupancy flags
- stack_overflow, stack_underflow  out  1  sticky error flags

## Operation
- Bubble counter bcnt (width clog2(BUBBLE_CYCLES+1)): if ctrl_stall=1, load BUBBLE_CYCLES on the next edge, even when bcnt is nonzero (reload, not add). Otherwise decrement while nonzero.
- ctrl_instr = NOP_INSTR when sstall=1 or bcnt≠0; else instruction. Combinational. bubble_active = (bcnt≠0).
- Register file: 8 × DATA_W entries, all writable including index 0. Write on edge when reg_write=1. Reads are combinational. Bypass: if reg_write=1 and write_address equals a read index, that port returns write_data in the same cycle.
- Stack: pointer sp ranges 0..STACK_DEPTH. stack_empty = (sp==0); stack_full = (sp==STACK_DEPTH). stack_out = mem[sp-1], or 0 when empty.
  - push only, not full: mem[sp] ← stack_in, sp+1. Push when full: ignored, stack_overflow ← 1.
  - pop only, not empty: sp−1. Pop when empty: ignored, stack_underflow ← 1.
  - push and pop together, not empty: replace the top (mem[sp-1] ← stack_in, sp unchanged). When empty, acts as push only; no underflow is flagged.
- Sticky flags are cleared only by rst.
- Field outputs are pure slices of instruction. They are not affected by bubbles.

## Timing
- Reset (edge with rst=1): bcnt=0, sp=0, all registers 0, both sticky flags 0. After reset: ctrl_instr=instruction, stack_out=0, stack_empty=1, stack_full=0, bubble_active=0, read data 0 unless bypassed. rst overrides ctrl_stall, push, pop and reg_write in the same cycle.
- ctrl_stall high in cycle n → ctrl_instr=NOP in cycles n+1 … n+BUBBLE_CYCLES. This adds one register stage, matching the legacy one-cycle bubble when BUBBLE_CYCLES=1.
- Reset mid-bubble: ctrl_instr follows instruction from the cycle after the reset edge.
- Register write is visible via bypass in the write cycle and from storage afterwards. Stack updates are visible on stack_out in the cycle after the edge.

## Test plan
- Reset with stale state → all registers read 0, sp=0, stack_out=0, flags 0, ctrl_instr=instruction.
- BUBBLE_CYCLES=3, ctrl_stall pulsed in cycle 5 → ctrl_instr=NOP_INSTR in cycles 6–8 and instruction in cycle 9. A second pulse in cycle 7 extends the bubble through cycle 10. sstall alone gives a NOP in that cycle only.
- Write 8'hA5 to R3 while reading R3 on port 1 and port 2 (r2_sel selecting R3) → both ports return A5 in the same cycle and in the following cycles.
- STACK_DEPTH=8: push 12'h001…12'h008 → stack_full=1, stack_out=008. A ninth push of 12'h0FF is ignored and sets stack_overflow=1. Eight pops return 007…001 then 0 with stack_empty=1. A ninth pop sets stack_underflow=1.
- Simultaneous push 12'h123 and pop with sp=2 → sp stays 2 and stack_out=123. The same operation with sp=0 → sp=1, stack_out=123, and no underflow.
- rst asserted in cycle 2 of a 3-cycle bubble while sp=4 → next cycle ctrl_instr=instruction, sp=0, stack_empty=1.
